// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FSM encodings and watchdog default for the FP issue block
package fpu_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        OPHI = 3'd1,
        OPLO = 3'd2,
        WAIT = 3'd3,
        RES1 = 3'd4,
        KILL = 3'd5
    } fpu_state_t;

    localparam logic [7:0] WDOG_MAX_DEFAULT = 8'd200;

endpackage

// File: rtl/fpu_wdog.sv
// rtl/fpu_wdog.sv - busy-cycle watchdog counter for the FP issue block
module fpu_wdog (
    input  logic       clk,
    input  logic       reset_l,
    input  logic       enable,
    input  logic       clear,
    input  logic [7:0] max,
    output logic       expired
);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (!reset_l || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    // Fires on the enabled cycle that would make the count reach max.
    assign expired = enable && !clear && (count == max - 8'd1);

endmodule

// File: rtl/fpu_issue.sv
// rtl/fpu_issue.sv - sequences IU floating-point ops onto the FPU beat interface
module fpu_issue
    import fpu_pkg::*;
#(
    parameter logic [7:0] WDOG_MAX = WDOG_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        req_valid,
    input  logic [7:0]  req_op,
    input  logic        req_dprec,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    output logic        req_rdy,
    input  logic        iu_hold,
    input  logic        iu_kill,
    output logic [7:0]  fpop,
    output logic        fpop_valid,
    output logic [31:0] fpain,
    output logic [31:0] fpbin,
    output logic        fphold,
    output logic        fpkill,
    input  logic        fpbusyn,
    input  logic [31:0] fpout,
    output logic        res_valid,
    output logic [63:0] res_data,
    output logic        err_timeout
);

    fpu_state_t  state;
    logic        dprec_r;
    logic        seen_busy;
    logic        res_pend;
    logic        wdog_kill;
    logic        wdog_en;
    logic        wdog_clr;
    logic        wdog_expired;
    logic [31:0] a_lo;
    logic [31:0] b_lo;
    logic [31:0] res_hi;

    assign req_rdy   = (state == IDLE) && fpbusyn && !err_timeout && !iu_kill && !iu_hold;
    assign fphold    = iu_hold;
    assign fpkill    = wdog_kill || (iu_kill && (state != IDLE));
    // A finished result waits in res_pend until the IU is no longer held.
    assign res_valid = res_pend && !iu_hold;
    assign wdog_en   = (state == WAIT) && !fpbusyn && !iu_hold && !iu_kill;
    assign wdog_clr  = (state != WAIT);

    fpu_wdog u_wdog (
        .clk     (clk),
        .reset_l (reset_l),
        .enable  (wdog_en),
        .clear   (wdog_clr),
        .max     (WDOG_MAX),
        .expired (wdog_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state       <= IDLE;
            dprec_r     <= 1'b0;
            seen_busy   <= 1'b0;
            res_pend    <= 1'b0;
            wdog_kill   <= 1'b0;
            err_timeout <= 1'b0;
            fpop        <= '0;
            fpop_valid  <= 1'b0;
            fpain       <= '0;
            fpbin       <= '0;
            a_lo        <= '0;
            b_lo        <= '0;
            res_hi      <= '0;
            res_data    <= '0;
        end else begin
            wdog_kill <= 1'b0;
            if (iu_kill && (state != IDLE)) begin
                state      <= KILL;
                fpop_valid <= 1'b0;
                res_pend   <= 1'b0;
                seen_busy  <= 1'b0;
            end else if (!iu_hold) begin
                res_pend <= 1'b0;
                case (state)
                    IDLE: begin
                        if (req_valid && req_rdy) begin
                            fpop       <= req_op;
                            fpop_valid <= 1'b1;
                            dprec_r    <= req_dprec;
                            fpain      <= req_dprec ? req_a[63:32] : req_a[31:0];
                            fpbin      <= req_dprec ? req_b[63:32] : req_b[31:0];
                            a_lo       <= req_a[31:0];
                            b_lo       <= req_b[31:0];
                            state      <= OPHI;
                        end
                    end
                    OPHI: begin
                        fpop_valid <= 1'b0;
                        if (dprec_r) begin
                            fpain <= a_lo;
                            fpbin <= b_lo;
                            state <= OPLO;
                        end else begin
                            state <= WAIT;
                        end
                    end
                    OPLO: begin
                        if (!fpbusyn) seen_busy <= 1'b1;
                        state <= WAIT;
                    end
                    WAIT: begin
                        if (!fpbusyn) seen_busy <= 1'b1;
                        // Completion is busy seen low and now high again.
                        if (seen_busy && fpbusyn) begin
                            seen_busy <= 1'b0;
                            if (dprec_r) begin
                                res_hi <= fpout;
                                state  <= RES1;
                            end else begin
                                res_data <= {32'd0, fpout};
                                res_pend <= 1'b1;
                                state    <= IDLE;
                            end
                        end else if (wdog_expired) begin
                            seen_busy   <= 1'b0;
                            err_timeout <= 1'b1;
                            wdog_kill   <= 1'b1;
                            state       <= IDLE;
                        end
                    end
                    RES1: begin
                        res_data <= {res_hi, fpout};
                        res_pend <= 1'b1;
                        state    <= IDLE;
                    end
                    KILL: begin
                        if (fpbusyn) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
